// File: rtl/rv32_wb_pkg.sv
// Shared definitions for the register-file writeback arbiter.
// Contents: register-file geometry (XLEN, REG_ADDR_W), the arbiter
// state enum, and a helper that tells whether a destination register
// may be written (x0 is hard-wired to zero and never written).
package rv32_wb_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 2 ** REG_ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // buffer empty
        ST_HELD  = 2'd1,   // one mul/div result buffered
        ST_DRAIN = 2'd2    // buffer written while the pipeline is stalled
    } wb_state_e;

    function automatic logic rf_addr_writable(input logic [REG_ADDR_W-1:0] rd);
        return rd != '0;
    endfunction

endpackage

// File: rtl/wb_arbiter_if.sv
// Bus bundle between the CPU pipeline / mul-div unit (master side) and
// the writeback arbiter (slave side).
// Signals:
//   pipe_we/pipe_rd/pipe_data     in-order pipeline writeback request
//   md_valid/md_rd/md_data        mul/div result offer, md_ready accept
//   md_issue/md_issue_rd          mul/div issue with destination register
//   rs1/rs2, md_hazard            decode source registers and hazard flag
//   pipe_stall                    pipeline hold request
//   rf_we/rf_rd/rf_wdata          the single register-file write port
interface wb_arbiter_if;
    import rv32_wb_pkg::*;

    logic                  pipe_we;
    logic [REG_ADDR_W-1:0] pipe_rd;
    logic [XLEN-1:0]       pipe_data;
    logic                  md_valid;
    logic [REG_ADDR_W-1:0] md_rd;
    logic [XLEN-1:0]       md_data;
    logic                  md_ready;
    logic                  md_issue;
    logic [REG_ADDR_W-1:0] md_issue_rd;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  md_hazard;
    logic                  pipe_stall;
    logic                  rf_we;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [XLEN-1:0]       rf_wdata;

    modport master (
        output pipe_we, pipe_rd, pipe_data,
        output md_valid, md_rd, md_data,
        output md_issue, md_issue_rd, rs1, rs2,
        input  md_ready, md_hazard, pipe_stall,
        input  rf_we, rf_rd, rf_wdata
    );

    modport slave (
        input  pipe_we, pipe_rd, pipe_data,
        input  md_valid, md_rd, md_data,
        input  md_issue, md_issue_rd, rs1, rs2,
        output md_ready, md_hazard, pipe_stall,
        output rf_we, rf_rd, rf_wdata
    );

endinterface

// File: rtl/wb_scoreboard.sv
// Pending-result scoreboard for outstanding mul/div destinations.
// One bit per architectural register; issue sets a bit, the arbiter
// clears it when the matching result is written or discarded. A set
// and clear of the same bit in one cycle leaves the bit set, since the
// new issue is younger than the retiring result.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   i_set_en, i_set_rd    mul/div issued to i_set_rd (x0 ignored)
//   i_clr_en, i_clr_rd    result for i_clr_rd written or discarded
//   i_rs1, i_rs2          decode-stage source registers
//   o_hazard              a source register awaits a mul/div result
module wb_scoreboard
    import rv32_wb_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_set_en,
    input  logic [REG_ADDR_W-1:0] i_set_rd,
    input  logic                  i_clr_en,
    input  logic [REG_ADDR_W-1:0] i_clr_rd,
    input  logic [REG_ADDR_W-1:0] i_rs1,
    input  logic [REG_ADDR_W-1:0] i_rs2,
    output logic                  o_hazard
);

    logic [NUM_REGS-1:0] r_pend;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            logic w_set;
            logic w_clr;

            assign w_set = i_set_en && rf_addr_writable(i_set_rd)
                           && (i_set_rd == REG_ADDR_W'(gi));
            assign w_clr = i_clr_en && (i_clr_rd == REG_ADDR_W'(gi));

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_pend[gi] <= 1'b0;
                end else if (w_set) begin
                    r_pend[gi] <= 1'b1;
                end else if (w_clr) begin
                    r_pend[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign o_hazard = (rf_addr_writable(i_rs1) && r_pend[i_rs1])
                   || (rf_addr_writable(i_rs2) && r_pend[i_rs2]);

endmodule

// File: rtl/wb_arbiter.sv
// Register-file writeback arbiter: merges the in-order pipeline write
// and the out-of-order mul/div result onto one register-file write port.
// The pipeline always has priority; a colliding mul/div result is parked
// in a one-entry buffer and written in the next free cycle, or forced
// out by stalling the pipeline for one cycle (DRAIN).
// Build option: define WB_ARB_STARVE_EN to let the buffered result wait
// up to STARVE_LIMIT-1 busy cycles (saturating 3-bit counter) before the
// pipeline is stalled; without it the buffer is drained after one busy
// cycle.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   bus        wb_arbiter_if slave modport (pipeline, mul/div, decode
//              hazard and register-file write port signals)
module wb_arbiter
    import rv32_wb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk,
    input  logic         rst,
    wb_arbiter_if.slave  bus
);

    wb_state_e             r_state;
    logic                  r_md_ready;
    logic                  r_pipe_stall;
    logic [REG_ADDR_W-1:0] r_buf_rd;
    logic [XLEN-1:0]       r_buf_data;

    wb_state_e             w_state_next;
    logic                  w_sel_we;
    logic [REG_ADDR_W-1:0] w_sel_rd;
    logic [XLEN-1:0]       w_sel_data;
    logic                  w_capture;
    logic                  w_clr_en;
    logic [REG_ADDR_W-1:0] w_clr_rd;

`ifdef WB_ARB_STARVE_EN
    logic [2:0] r_cnt;
    logic [2:0] w_cnt_sat;
    logic       w_cnt_step;
    logic       w_starved;

    assign w_cnt_sat = (r_cnt == 3'd7) ? r_cnt : r_cnt + 3'd1;
    assign w_starved = int'({29'd0, w_cnt_sat}) >= (STARVE_LIMIT - 1);
`endif

    always_comb begin
        w_state_next = r_state;
        w_sel_we     = 1'b0;
        w_sel_rd     = bus.pipe_rd;
        w_sel_data   = bus.pipe_data;
        w_capture    = 1'b0;
        w_clr_en     = 1'b0;
        w_clr_rd     = bus.md_rd;
`ifdef WB_ARB_STARVE_EN
        w_cnt_step   = 1'b0;
`endif
        if (rst) begin
            // Only the pipeline passes during reset; the buffer is dropped.
            w_sel_we = bus.pipe_we;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.pipe_we) begin
                        w_sel_we = 1'b1;
                        if (bus.md_valid) begin
                            if (bus.md_rd != bus.pipe_rd) begin
                                w_capture    = 1'b1;
                                w_state_next = ST_HELD;
                            end else begin
                                // Younger pipeline write to the same rd wins.
                                w_clr_en = 1'b1;
                            end
                        end
                    end else if (bus.md_valid) begin
                        w_sel_we   = 1'b1;
                        w_sel_rd   = bus.md_rd;
                        w_sel_data = bus.md_data;
                        w_clr_en   = 1'b1;
                    end
                end
                ST_HELD: begin
                    w_clr_rd = r_buf_rd;
                    w_sel_we = 1'b1;
                    if (!bus.pipe_we) begin
                        w_sel_rd     = r_buf_rd;
                        w_sel_data   = r_buf_data;
                        w_clr_en     = 1'b1;
                        w_state_next = ST_IDLE;
                    end else if (bus.pipe_rd == r_buf_rd) begin
                        w_clr_en     = 1'b1;
                        w_state_next = ST_IDLE;
                    end else begin
`ifdef WB_ARB_STARVE_EN
                        w_cnt_step = 1'b1;
                        if (w_starved) begin
                            w_state_next = ST_DRAIN;
                        end
`else
                        w_state_next = ST_DRAIN;
`endif
                    end
                end
                ST_DRAIN: begin
                    w_sel_we     = 1'b1;
                    w_sel_rd     = r_buf_rd;
                    w_sel_data   = r_buf_data;
                    w_clr_en     = 1'b1;
                    w_clr_rd     = r_buf_rd;
                    w_state_next = ST_IDLE;
                end
                default: begin
                    w_state_next = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_md_ready   <= 1'b1;
            r_pipe_stall <= 1'b0;
            r_buf_rd     <= '0;
            r_buf_data   <= '0;
`ifdef WB_ARB_STARVE_EN
            r_cnt        <= 3'd0;
`endif
        end else begin
            r_state      <= w_state_next;
            r_md_ready   <= (w_state_next == ST_IDLE);
            r_pipe_stall <= (w_state_next == ST_DRAIN);
            if (w_capture) begin
                r_buf_rd   <= bus.md_rd;
                r_buf_data <= bus.md_data;
            end
`ifdef WB_ARB_STARVE_EN
            if (w_capture) begin
                r_cnt <= 3'd0;
            end else if (w_cnt_step) begin
                r_cnt <= w_cnt_sat;
            end
`endif
        end
    end

    wb_scoreboard u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .i_set_en (bus.md_issue),
        .i_set_rd (bus.md_issue_rd),
        .i_clr_en (w_clr_en),
        .i_clr_rd (w_clr_rd),
        .i_rs1    (bus.rs1),
        .i_rs2    (bus.rs2),
        .o_hazard (bus.md_hazard)
    );

    assign bus.md_ready   = r_md_ready;
    assign bus.pipe_stall = r_pipe_stall;
    assign bus.rf_we      = w_sel_we && rf_addr_writable(w_sel_rd);
    assign bus.rf_rd      = w_sel_rd;
    assign bus.rf_wdata   = w_sel_data;

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios followed by
// randomized traffic, all compared against a behavioural model of the
// writeback rules (buffer occupancy, busy-cycle count, pending set).
module tb_wb_arbiter;
    import rv32_wb_pkg::*;

    localparam int STARVE_LIMIT = 4;
`ifdef WB_ARB_STARVE_EN
    localparam int DRAIN_AFTER = ((STARVE_LIMIT - 1) < 1) ? 1 : (STARVE_LIMIT - 1);
`else
    localparam int DRAIN_AFTER = 1;
`endif

    logic clk;
    logic rst;
    wb_arbiter_if bus ();

    wb_arbiter #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model state
    bit          m_held;
    bit          m_drain;
    int          m_busy;
    logic [4:0]  m_buf_rd;
    logic [31:0] m_buf_data;
    bit          m_pend [32];
    bit          m_md_taken;

    // Expected outputs for the current cycle
    logic        e_ready, e_stall, e_haz, e_we;
    logic [4:0]  e_rd;
    logic [31:0] e_data;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
        end
    endtask

    task automatic model_clear();
        m_held = 0; m_drain = 0; m_busy = 0;
        m_buf_rd = '0; m_buf_data = '0;
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
    endtask

    // Let inputs settle, predict outputs, compare.
    task automatic settle();
        bit has;
        #1;
        has = 0; e_rd = bus.pipe_rd; e_data = bus.pipe_data;
        if (rst) begin
            has = bus.pipe_we;
        end else if (m_drain) begin
            has = 1; e_rd = m_buf_rd; e_data = m_buf_data;
        end else if (m_held) begin
            has = 1;
            if (!bus.pipe_we) begin e_rd = m_buf_rd; e_data = m_buf_data; end
        end else if (bus.pipe_we) begin
            has = 1;
        end else if (bus.md_valid) begin
            has = 1; e_rd = bus.md_rd; e_data = bus.md_data;
        end
        e_we    = has && (e_rd != 0);
        e_ready = !m_held;
        e_stall = m_drain;
        e_haz   = (bus.rs1 != 0 && m_pend[bus.rs1]) || (bus.rs2 != 0 && m_pend[bus.rs2]);
        chk("md_ready", 32'(bus.md_ready), 32'(e_ready));
        chk("pipe_stall", 32'(bus.pipe_stall), 32'(e_stall));
        chk("md_hazard", 32'(bus.md_hazard), 32'(e_haz));
        chk("rf_we", 32'(bus.rf_we), 32'(e_we));
        if (e_we) begin
            chk("rf_rd", 32'(bus.rf_rd), 32'(e_rd));
            chk("rf_wdata", bus.rf_wdata, e_data);
        end
        $display("cyc %0d rst=%0d rf_we=%0d rf_rd=%0d rf_wdata=%h ready=%0d stall=%0d haz=%0d",
                 cyc, rst, bus.rf_we, bus.rf_rd, bus.rf_wdata, bus.md_ready,
                 bus.pipe_stall, bus.md_hazard);
    endtask

    // Clock edge: advance the model with the inputs that were applied.
    task automatic adv();
        @(posedge clk);
        m_md_taken = 0;
        if (rst) begin
            model_clear();
        end else begin
            if (m_drain) begin
                m_pend[m_buf_rd] = 0; m_held = 0; m_drain = 0;
            end else if (m_held) begin
                if (!bus.pipe_we || bus.pipe_rd == m_buf_rd) begin
                    m_pend[m_buf_rd] = 0; m_held = 0;
                end else begin
                    m_busy++;
                    if (m_busy == DRAIN_AFTER) m_drain = 1;
                end
            end else if (bus.md_valid) begin
                m_md_taken = 1;
                if (bus.pipe_we && bus.md_rd != bus.pipe_rd) begin
                    m_held = 1; m_busy = 0;
                    m_buf_rd = bus.md_rd; m_buf_data = bus.md_data;
                end else begin
                    m_pend[bus.md_rd] = 0;
                end
            end
            if (bus.md_issue && bus.md_issue_rd != 0) m_pend[bus.md_issue_rd] = 1;
        end
        @(negedge clk);
        cyc++;
    endtask

    task automatic quiet();
        rst = 0;
        bus.pipe_we = 0; bus.pipe_rd = 0; bus.pipe_data = 0;
        bus.md_valid = 0; bus.md_rd = 0; bus.md_data = 0;
        bus.md_issue = 0; bus.md_issue_rd = 0; bus.rs1 = 0; bus.rs2 = 0;
    endtask

    logic [4:0] iss_q [$];

    initial begin
        quiet();
        rst = 1;
        model_clear();
        @(posedge clk);
        @(negedge clk);
        rst = 0;

        // Reset state
        settle();
        chk("rst_md_ready", 32'(bus.md_ready), 32'd1);
        chk("rst_pipe_stall", 32'(bus.pipe_stall), 32'd0);
        chk("rst_md_hazard", 32'(bus.md_hazard), 32'd0);
        adv();

        // Pipeline write alone passes through
        bus.pipe_we = 1; bus.pipe_rd = 5; bus.pipe_data = 32'h11;
        settle();
        chk("pass_we", 32'(bus.rf_we), 32'd1);
        chk("pass_rd", 32'(bus.rf_rd), 32'd5);
        chk("pass_data", bus.rf_wdata, 32'h11);
        chk("pass_ready", 32'(bus.md_ready), 32'd1);
        adv();

        // Collision: pipeline first, buffered md result next free cycle
        bus.md_valid = 1; bus.md_rd = 7; bus.md_data = 32'hAA;
        bus.pipe_we = 1; bus.pipe_rd = 3; bus.pipe_data = 32'h33;
        settle();
        chk("coll_rd", 32'(bus.rf_rd), 32'd3);
        chk("coll_ready", 32'(bus.md_ready), 32'd1);
        adv();
        quiet();
        settle();
        chk("held_ready", 32'(bus.md_ready), 32'd0);
        chk("held_rd", 32'(bus.rf_rd), 32'd7);
        chk("held_data", bus.rf_wdata, 32'hAA);
        adv();
        settle();
        chk("after_ready", 32'(bus.md_ready), 32'd1);
        adv();

        // Starvation: pipeline busy every cycle until the drain stall
        bus.md_valid = 1; bus.md_rd = 7; bus.md_data = 32'hBB;
        bus.pipe_we = 1; bus.pipe_rd = 3; bus.pipe_data = 32'h100;
        settle();
        adv();
        bus.md_valid = 0;
        for (int k = 1; k <= DRAIN_AFTER + 1; k++) begin
            bus.pipe_rd = 2;
            if (k <= DRAIN_AFTER) bus.pipe_data = 32'h100 + 32'(k);
            settle();
            if (k == DRAIN_AFTER + 1) begin
                chk("drain_stall", 32'(bus.pipe_stall), 32'd1);
                chk("drain_rd", 32'(bus.rf_rd), 32'd7);
                chk("drain_data", bus.rf_wdata, 32'hBB);
            end else begin
                chk("busy_stall", 32'(bus.pipe_stall), 32'd0);
                chk("busy_rd", 32'(bus.rf_rd), 32'd2);
            end
            adv();
        end
        settle();
        chk("stalled_wr_rd", 32'(bus.rf_rd), 32'd2);
        chk("stalled_wr_data", bus.rf_wdata, 32'h100 + 32'(DRAIN_AFTER));
        adv();

        // Same-rd collision: younger pipeline write wins, pending cleared
        quiet();
        bus.md_issue = 1; bus.md_issue_rd = 9;
        settle(); adv();
        bus.md_issue = 0; bus.rs1 = 9;
        settle();
        chk("haz9_set", 32'(bus.md_hazard), 32'd1);
        adv();
        bus.md_valid = 1; bus.md_rd = 9; bus.md_data = 32'hDD;
        bus.pipe_we = 1; bus.pipe_rd = 9; bus.pipe_data = 32'hEE;
        settle();
        chk("same_rd_data", bus.rf_wdata, 32'hEE);
        adv();
        bus.md_valid = 0; bus.pipe_we = 0;
        settle();
        chk("haz9_clr", 32'(bus.md_hazard), 32'd0);
        adv();

        // Issue to x0 never creates a hazard; rd4 hazard until written
        quiet();
        bus.md_issue = 1; bus.md_issue_rd = 0;
        settle(); adv();
        bus.md_issue = 0;
        settle();
        chk("haz_x0", 32'(bus.md_hazard), 32'd0);
        adv();
        bus.md_issue = 1; bus.md_issue_rd = 4;
        settle(); adv();
        bus.md_issue = 0; bus.rs2 = 4;
        settle();
        chk("haz4_a", 32'(bus.md_hazard), 32'd1);
        adv();
        bus.md_valid = 1; bus.md_rd = 4; bus.md_data = 32'h44;
        settle();
        chk("haz4_b", 32'(bus.md_hazard), 32'd1);
        chk("md4_rd", 32'(bus.rf_rd), 32'd4);
        adv();
        bus.md_valid = 0;
        settle();
        chk("haz4_clr", 32'(bus.md_hazard), 32'd0);
        adv();

        // Reset while HELD discards the buffered result
        quiet();
        bus.md_valid = 1; bus.md_rd = 6; bus.md_data = 32'h66;
        bus.pipe_we = 1; bus.pipe_rd = 1; bus.pipe_data = 32'h01;
        settle(); adv();
        quiet();
        rst = 1;
        settle();
        chk("rst_held_we", 32'(bus.rf_we), 32'd0);
        adv();
        rst = 0;
        settle();
        chk("rst_held_ready", 32'(bus.md_ready), 32'd1);
        chk("rst_held_we2", 32'(bus.rf_we), 32'd0);
        adv();

        // Randomized traffic
        iss_q.delete();
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 59) == 0) begin
                quiet();
                rst = 1;
                iss_q.delete();
            end else begin
                rst = 0;
                if (bus.md_valid && m_md_taken) bus.md_valid = 0;
                if (!m_drain) begin
                    bus.pipe_we   = 1'($urandom_range(0, 1));
                    bus.pipe_rd   = 5'($urandom_range(0, 7));
                    bus.pipe_data = $urandom;
                    bus.md_issue  = ($urandom_range(0, 3) == 0);
                    bus.md_issue_rd = 5'($urandom_range(0, 7));
                    if (bus.md_issue) iss_q.push_back(bus.md_issue_rd);
                end else begin
                    bus.md_issue = 0;
                end
                if (!bus.md_valid && iss_q.size() > 0 && $urandom_range(0, 1) == 1) begin
                    bus.md_valid = 1;
                    bus.md_rd    = iss_q.pop_front();
                    bus.md_data  = $urandom;
                end
                bus.rs1 = 5'($urandom_range(0, 7));
                bus.rs2 = 5'($urandom_range(0, 7));
            end
            settle();
            adv();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: consecutive HELD cycles allowed before the pipeline is stalled to drain.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 pipe_we / pipe_rd / pipe_data  input  1/5/32  in-order pipeline writeback request (the write-data mux output).
REQ-005 md_valid / md_rd / md_data  input  1/5/32  multi-cycle mul/div result offer.
REQ-006 md_ready  output  1  md result accepted this cycle when md_valid&&md_ready.
REQ-007 md_issue / md_issue_rd  input  1/5  mul/div instruction issued, destination register.
REQ-008 rs1 / rs2  input  5/5  source registers of the instruction in decode.
REQ-009 md_hazard  output  1  rs1 or rs2 awaits an outstanding mul/div result.
REQ-010 pipe_stall  output  1  pipeline shall hold; pipe_* inputs stay stable while it is high.
REQ-011 rf_we / rf_rd / rf_wdata  output  1/5/32  the single register-file write port.

Function
REQ-012 One register-file write per cycle; rf_we SHALL be 0 whenever rf_rd==0.
REQ-013 States: IDLE (buffer empty), HELD (one md result buffered), DRAIN (buffer written, pipeline stalled).
REQ-014 IDLE: md_ready=1; pipe_stall=0; a pipeline write passes through combinationally with zero latency.
REQ-015 IDLE, md_valid with pipe_we=0: md result written the same cycle; state stays IDLE.
REQ-016 IDLE, md_valid with pipe_we=1 and md_rd!=pipe_rd: pipeline written; md result captured; next state HELD, starve counter cleared to 0.
REQ-017 IDLE, md_valid with pipe_we=1 and md_rd==pipe_rd: pipeline written; md result accepted and discarded (younger write wins); state stays IDLE.
REQ-018 HELD: md_ready=0; pipe_we=0 -> buffer written, next state IDLE.
REQ-019 HELD, pipe_we=1 with pipe_rd==buffered rd: pipeline written; buffer discarded; next state IDLE.
REQ-020 HELD, pipe_we=1 otherwise: pipeline written; counter increments; on reaching STARVE_LIMIT-1 next state DRAIN.
REQ-021 DRAIN: pipe_stall=1; md_ready=0; buffer written; next state IDLE; the held pipeline write completes the following cycle.
REQ-022 Starve counter is 3 bits and saturates; it never wraps.
REQ-023 Scoreboard: 32-bit pending mask; md_issue with md_issue_rd!=0 sets a bit; a bit is cleared when its md result is written or discarded.
REQ-024 Set and clear of the same bit in one cycle: set wins.
REQ-025 md_hazard = (rs1!=0 && pending[rs1]) || (rs2!=0 && pending[rs2]), combinational.

Reset
REQ-026 On rst: state IDLE, buffer invalid, counter 0, pending mask 0.
REQ-027 After reset: md_ready=1, pipe_stall=0, md_hazard=0, and rf_* follow pipe_*.
REQ-028 rst mid-HELD or mid-DRAIN discards the buffered result without writing it.

Configuration
REQ-029 Macro WB_ARB_STARVE_EN defined: HELD/DRAIN behave per REQ-018..REQ-022.
REQ-030 Macro undefined: no counter; HELD with pipe_we=1 and no rd match moves to DRAIN on the next cycle, i.e. the mul/div result is buffered for at most one cycle.

Structure
REQ-031 Package rv32_wb_pkg holds the state enum, XLEN=32 and REG_ADDR_W=5.
REQ-032 The scoreboard is the sub-module wb_scoreboard; wb_arbiter holds the FSM, buffer and write mux.

Verification
REQ-033 pipe_we=1 rd=5 data=0x11 alone -> rf_we=1 rd=5 wdata=0x11 same cycle; md_ready=1.
REQ-034 md_valid rd=7 data=0xAA and pipe_we=1 rd=3 -> rd3 written; next cycle pipe_we=0 -> rd7=0xAA written; md_ready=0 only in the HELD cycle.
REQ-035 Held md result with pipe_we=1 every cycle, STARVE_LIMIT=4 -> pipe_stall=1 on the 4th cycle, buffered value written then; stalled pipe write written the next cycle.
REQ-036 Same-cycle md rd=9 and pipe rd=9 -> only pipe_data written; pending[9] cleared; md_hazard for rs1=9 drops to 0.
REQ-037 md_issue rd=0 then rs1=0 -> md_hazard=0; md_issue rd=4 then rs2=4 -> md_hazard=1 until rd4 is written.
REQ-038 rst asserted in HELD -> next cycle state IDLE, no rf write of the buffered value, md_ready=1.
